store_drain: RTL and testbench

Read-side consumer for the CPU store-buffer FIFO: pops one {addr, data, strb} entry at a time from a show-ahead FIFO and issues it as a single AXI4-Lite write transaction (AW, W, B). It sits between the LSU store buffer and the data-side AXI-Lite write channel. It holds exactly one transaction in flight and reports sticky write errors to the core.

---
 rtl/store_drain.sv | 167 ++++++++++++++++
 tb/tb_store_drain.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_drain.sv
// store_drain: pops {addr, data, strb} entries from a show-ahead store-buffer
// FIFO and issues each one as a single AXI4-Lite write (AW, W, B), with one
// transaction in flight at a time. Non-OKAY write responses raise a sticky
// error flag and capture the address of the first failing write.
//
// Optional feature macro: DRAIN_B2B_EN. When defined, the cycle that accepts
// a B response may also pop the next entry and go straight back to SEND,
// removing the idle bubble between writes.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   fifo_data           FIFO head entry {addr, data, strb}
//   fifo_empty          FIFO empty flag
//   fifo_rd_en          pop strobe (combinational)
//   hold                blocks new pops; an in-flight write still completes
//   aw*/w*/b*           AXI4-Lite write address, data and response channels
//   drained             idle with the FIFO empty
//   err, err_addr       sticky write error and first failing address
module store_drain #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [ADDR_WIDTH+DATA_WIDTH+DATA_WIDTH/8-1:0] fifo_data,
  input  logic                                         fifo_empty,
  output logic                                         fifo_rd_en,
  input  logic                                         hold,
  output logic                                         awvalid,
  input  logic                                         awready,
  output logic [ADDR_WIDTH-1:0]                        awaddr,
  output logic                                         wvalid,
  input  logic                                         wready,
  output logic [DATA_WIDTH-1:0]                        wdata,
  output logic [DATA_WIDTH/8-1:0]                      wstrb,
  input  logic                                         bvalid,
  output logic                                         bready,
  input  logic [1:0]                                   bresp,
  output logic                                         drained,
  output logic                                         err,
  output logic [ADDR_WIDTH-1:0]                        err_addr
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nx;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [STRB_W-1:0]       strb_q;
  logic                    aw_done;
  logic                    w_done;
  logic                    aw_hs;
  logic                    w_hs;
  logic                    pop;

  assign aw_hs  = awvalid & awready;
  assign w_hs   = wvalid & wready;
  assign awaddr = addr_q;
  assign wdata  = data_q;
  assign wstrb  = strb_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (pop) begin
          state_nx = SEND;
        end
      end
      SEND: begin
        // Either channel may finish first; count this cycle's handshakes too.
        if ((aw_done || aw_hs) && (w_done || w_hs)) begin
          state_nx = RESP;
        end
      end
      RESP: begin
        if (bvalid) begin
          state_nx = pop ? SEND : IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    awvalid = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        pop = !fifo_empty && !hold;
      end
      SEND: begin
        awvalid = !aw_done;
        wvalid  = !w_done;
      end
      RESP: begin
        bready = 1'b1;
`ifdef DRAIN_B2B_EN
        pop = bvalid && !fifo_empty && !hold;
`else
        pop = 1'b0;
`endif
      end
      default: begin
        pop = 1'b0;
      end
    endcase
    // A reset cycle abandons everything, including a pop decided this cycle.
    if (rst) begin
      pop = 1'b0;
    end
    fifo_rd_en = pop;
    drained    = (state == IDLE) && fifo_empty;
  end

  // Entry capture, per-channel handshake tracking and sticky error capture
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      data_q   <= '0;
      strb_q   <= '0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      err      <= 1'b0;
      err_addr <= '0;
    end else begin
      if (pop) begin
        {addr_q, data_q, strb_q} <= fifo_data;
        aw_done                  <= 1'b0;
        w_done                   <= 1'b0;
      end else begin
        if (aw_hs) begin
          aw_done <= 1'b1;
        end
        if (w_hs) begin
          w_done <= 1'b1;
        end
      end
      // addr_q still holds the responding write even on a back-to-back pop.
      if ((state == RESP) && bvalid && (bresp != 2'b00) && !err) begin
        err      <= 1'b1;
        err_addr <= addr_q;
      end
    end
  end

endmodule

// File: tb/tb_store_drain.sv
module tb_store_drain;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned EW = AW + DW + SW;
`ifdef DRAIN_B2B_EN
  localparam int PERIOD = 2;
`else
  localparam int PERIOD = 3;
`endif

  logic          clk;
  logic          rst;
  logic [EW-1:0] fifo_data;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic          hold;
  logic          awvalid;
  logic          awready;
  logic [AW-1:0] awaddr;
  logic          wvalid;
  logic          wready;
  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;
  logic          bvalid;
  logic          bready;
  logic [1:0]    bresp;
  logic          drained;
  logic          err;
  logic [AW-1:0] err_addr;

  store_drain #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .hold(hold),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .drained(drained), .err(err), .err_addr(err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model contents, scoreboard of expected entries, queued B responses
  logic [EW-1:0] fifo_q[$];
  logic [EW-1:0] exp_q[$];
  logic [1:0]    bresp_q[$];
  int            pop_cyc[$];
  logic [EW-1:0] cur_exp = '0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pops  = 0;
  int aw_cnt = 0;
  int w_cnt  = 0;
  int b_cnt  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? '0 : fifo_q[0];
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    fifo_q.push_back({a, d, s});
    exp_q.push_back({a, d, s});
    refresh();
  endtask

  // One clock: sample/check at negedge, then update bench-side models after posedge.
  task automatic cycle();
    bit popped;
    @(negedge clk);
    chk("no_pop_on_empty", 64'(fifo_rd_en && fifo_empty), 64'(0));
    popped = fifo_rd_en;
    if (popped) begin
      pops++;
      pop_cyc.push_back(cyc);
      if (exp_q.size() != 0) cur_exp = exp_q.pop_front();
    end
    if (awvalid) chk("awaddr", 64'(awaddr), 64'(cur_exp[EW-1:DW+SW]));
    if (wvalid) begin
      chk("wdata", 64'(wdata), 64'(cur_exp[DW+SW-1:SW]));
      chk("wstrb", 64'(wstrb), 64'(cur_exp[SW-1:0]));
    end
    if (awvalid && awready) aw_cnt++;
    if (wvalid && wready) w_cnt++;
    if (bvalid && bready) begin
      b_cnt++;
      if (bresp_q.size() != 0) bresp_q.delete(0);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (popped && fifo_q.size() != 0) fifo_q.delete(0);
    refresh();
    bvalid = bready;
    bresp  = (bresp_q.size() != 0) ? bresp_q[0] : 2'b00;
    #1;
  endtask

  task automatic run_until_drained(input int budget, input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      cycle();
      done = drained;
    end
    chk(tag, 64'(done), 64'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int a0;
    int w0;
    int idx0;

    rst = 1'b1; hold = 1'b0; awready = 1'b1; wready = 1'b1;
    bvalid = 1'b0; bresp = 2'b00;
    refresh();
    cycle();
    cycle();

    // Reset state
    chk("rst_fifo_rd_en", 64'(fifo_rd_en), 64'(0));
    chk("rst_awvalid", 64'(awvalid), 64'(0));
    chk("rst_wvalid", 64'(wvalid), 64'(0));
    chk("rst_bready", 64'(bready), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_err_addr", 64'(err_addr), 64'(0));
    chk("rst_drained", 64'(drained), 64'(1));
    rst = 1'b0;

    // Single entry, all readies high
    p0 = pops;
    push(32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
    #1;
    chk("t1_pop_n", 64'(fifo_rd_en), 64'(1));
    chk("t1_drained_n", 64'(drained), 64'(0));
    cycle();
    chk("t1_pops", 64'(pops - p0), 64'(1));
    chk("t1_awvalid_n1", 64'(awvalid), 64'(1));
    chk("t1_wvalid_n1", 64'(wvalid), 64'(1));
    chk("t1_awaddr_n1", 64'(awaddr), 64'(32'h8000_0010));
    chk("t1_wdata_n1", 64'(wdata), 64'(32'hDEAD_BEEF));
    chk("t1_rd_en_n1", 64'(fifo_rd_en), 64'(0));
    cycle();
    chk("t1_bready_n2", 64'(bready), 64'(1));
    chk("t1_awvalid_n2", 64'(awvalid), 64'(0));
    chk("t1_wvalid_n2", 64'(wvalid), 64'(0));
    chk("t1_drained_n2", 64'(drained), 64'(0));
    cycle();
    chk("t1_drained_n3", 64'(drained), 64'(1));
    chk("t1_bready_n3", 64'(bready), 64'(0));
    chk("t1_pops_end", 64'(pops - p0), 64'(1));

    // W accepted three cycles before AW
    p0 = pops; a0 = aw_cnt; w0 = w_cnt;
    awready = 1'b0;
    push(32'h0000_1234, 32'h0102_0304, 4'h3);
    cycle();
    chk("t2_awvalid_n1", 64'(awvalid), 64'(1));
    chk("t2_wvalid_n1", 64'(wvalid), 64'(1));
    cycle();
    chk("t2_wvalid_n2", 64'(wvalid), 64'(0));
    chk("t2_awvalid_n2", 64'(awvalid), 64'(1));
    chk("t2_bready_n2", 64'(bready), 64'(0));
    cycle();
    chk("t2_awvalid_n3", 64'(awvalid), 64'(1));
    chk("t2_bready_n3", 64'(bready), 64'(0));
    cycle();
    chk("t2_awvalid_n4", 64'(awvalid), 64'(1));
    chk("t2_bready_n4", 64'(bready), 64'(0));
    awready = 1'b1;
    cycle();
    chk("t2_bready_n5", 64'(bready), 64'(1));
    chk("t2_awvalid_n5", 64'(awvalid), 64'(0));
    run_until_drained(10, "t2_drain_timeout");
    chk("t2_pops", 64'(pops - p0), 64'(1));
    chk("t2_aw_hs", 64'(aw_cnt - a0), 64'(1));
    chk("t2_w_hs", 64'(w_cnt - w0), 64'(1));

    // Four queued entries, immediate B
    p0 = pops; a0 = aw_cnt;
    idx0 = pop_cyc.size();
    push(32'h0000_0100, 32'h1111_1111, 4'hF);
    push(32'h0000_0104, 32'h2222_2222, 4'h1);
    push(32'h0000_0108, 32'h3333_3333, 4'h8);
    push(32'h0000_010C, 32'h4444_4444, 4'hC);
    run_until_drained(40, "t3_drain_timeout");
    chk("t3_pops", 64'(pops - p0), 64'(4));
    chk("t3_aw_hs", 64'(aw_cnt - a0), 64'(4));
    if (pop_cyc.size() - idx0 == 4) begin
      for (int k = 1; k < 4; k++)
        chk("t3_pop_spacing", 64'(pop_cyc[idx0+k] - pop_cyc[idx0+k-1]), 64'(PERIOD));
    end
    chk("t3_err", 64'(err), 64'(0));

    // Error responses on the second and third of three writes
    p0 = pops; a0 = b_cnt;
    bresp_q.push_back(2'b00);
    bresp_q.push_back(2'b10);
    bresp_q.push_back(2'b11);
    push(32'h0000_0200, 32'hAAAA_0000, 4'hF);
    push(32'h0000_0204, 32'hAAAA_0001, 4'hF);
    push(32'h0000_0208, 32'hAAAA_0002, 4'hF);
    run_until_drained(40, "t4_drain_timeout");
    chk("t4_pops", 64'(pops - p0), 64'(3));
    chk("t4_b_hs", 64'(b_cnt - a0), 64'(3));
    chk("t4_err", 64'(err), 64'(1));
    chk("t4_err_addr", 64'(err_addr), 64'(32'h0000_0204));

    // hold blocks pops from IDLE
    p0 = pops;
    hold = 1'b1;
    push(32'h0000_0300, 32'h5555_0000, 4'hF);
    push(32'h0000_0304, 32'h5555_0001, 4'hF);
    #1;
    chk("t5_hold_rd_en", 64'(fifo_rd_en), 64'(0));
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("t5_hold_rd_en_c", 64'(fifo_rd_en), 64'(0));
      chk("t5_hold_drained", 64'(drained), 64'(0));
    end
    chk("t5_hold_pops", 64'(pops - p0), 64'(0));
    hold = 1'b0;
    run_until_drained(20, "t5_release_timeout");
    chk("t5_release_pops", 64'(pops - p0), 64'(2));

    // hold raised while a write is in SEND
    p0 = pops;
    push(32'h0000_0400, 32'h6666_0000, 4'hF);
    push(32'h0000_0404, 32'h6666_0001, 4'hF);
    cycle();
    chk("t5b_in_send", 64'(awvalid), 64'(1));
    hold = 1'b1;
    for (int k = 0; k < 6; k++) cycle();
    chk("t5b_pops", 64'(pops - p0), 64'(1));
    chk("t5b_idle_awvalid", 64'(awvalid), 64'(0));
    chk("t5b_idle_bready", 64'(bready), 64'(0));
    chk("t5b_drained", 64'(drained), 64'(0));
    chk("t5b_rd_en", 64'(fifo_rd_en), 64'(0));
    chk("t5b_err_sticky", 64'(err), 64'(1));
    hold = 1'b0;
    run_until_drained(20, "t5b_release_timeout");
    chk("t5b_release_pops", 64'(pops - p0), 64'(2));

    // Reset while in SEND abandons the write
    p0 = pops;
    awready = 1'b0; wready = 1'b0;
    push(32'h0000_0500, 32'h7777_0000, 4'hF);
    push(32'h0000_0504, 32'h7777_0001, 4'h7);
    cycle();
    chk("t6_awvalid_pre", 64'(awvalid), 64'(1));
    rst = 1'b1;
    cycle();
    chk("t6_awvalid", 64'(awvalid), 64'(0));
    chk("t6_wvalid", 64'(wvalid), 64'(0));
    chk("t6_bready", 64'(bready), 64'(0));
    chk("t6_err", 64'(err), 64'(0));
    chk("t6_err_addr", 64'(err_addr), 64'(0));
    chk("t6_rd_en_in_rst", 64'(fifo_rd_en), 64'(0));
    cycle();
    chk("t6_pops_in_rst", 64'(pops - p0), 64'(1));
    rst = 1'b0;
    awready = 1'b1; wready = 1'b1;
    run_until_drained(20, "t6_drain_timeout");
    chk("t6_pops_after", 64'(pops - p0), 64'(2));
    chk("t6_err_after", 64'(err), 64'(0));
    chk("sb_empty", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
